// File: rtl/picorv32_memresp_pkg.sv
// Shared types, widths and helpers for the picorv32 memory responder.
package picorv32_memresp_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned STALL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [STALL_W-1:0] clamp_wait(input logic [STALL_W-1:0] sel,
                                                    input logic [STALL_W-1:0] max_wait);
    return (sel > max_wait) ? max_wait : sel;
  endfunction

endpackage

// File: rtl/picorv32_mem_responder_if.sv
// picorv32 native memory bus bundle; master is the core, slave is the responder.
interface picorv32_mem_responder_if
  import picorv32_memresp_pkg::*;
(
  input logic clk
);

  logic              mem_valid;
  logic              mem_instr;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  clk,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  clk,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/picorv32_memresp_ram.sv
// Byte-enable backing store: async clear on reset, one combinational read port,
// one strobed synchronous write port.
module picorv32_memresp_ram
  import picorv32_memresp_pkg::*;
#(
  parameter  int unsigned MEM_WORDS = 256,
  localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32 memory responder with programmable wait states and byte-strobed store.
// Optional MEMRESP_PROTOCOL_CHECK_EN adds a sticky request-stability checker.
module picorv32_mem_responder
  import picorv32_memresp_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [STRB_W-1:0]  mem_wstrb,
  output logic               mem_ready,
  output logic [DATA_W-1:0]  mem_rdata,
  input  logic [STALL_W-1:0] wait_sel,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               proto_err
);

  localparam int unsigned        AW    = $clog2(MEM_WORDS);
  localparam logic [STALL_W-1:0] MAX_W = STALL_W'(MAX_WAIT);

  state_t              state;
  logic [AW-1:0]       lat_idx;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;
  logic [DATA_W-1:0]   rd_word;
  logic [STALL_W-1:0]  load_cnt;
  logic                wr_en;

  assign load_cnt = clamp_wait(wait_sel, MAX_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      stall_cnt <= '0;
      mem_ready <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            lat_idx   <= mem_addr[AW+1:2];
            lat_wdata <= mem_wdata;
            lat_wstrb <= mem_wstrb;
            stall_cnt <= load_cnt;
            if (load_cnt != '0) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          stall_cnt <= stall_cnt - 1'b1;
          if (stall_cnt == STALL_W'(1)) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          stall_cnt <= '0;
          mem_ready <= 1'b0;
        end
      endcase
    end
  end

  // Write commits on the RESP-ending edge, so the read port still shows the old word.
  assign wr_en     = (state == RESP) && (lat_wstrb != '0);
  assign mem_rdata = ((state == RESP) && (lat_wstrb == '0)) ? rd_word : '0;

  picorv32_memresp_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .rd_idx (lat_idx),
    .rd_data(rd_word),
    .wr_en  (wr_en),
    .wr_idx (lat_idx),
    .wr_strb(lat_wstrb),
    .wr_data(lat_wdata)
  );

`ifdef MEMRESP_PROTOCOL_CHECK_EN
  logic [31:0] chk_addr;
  logic        chk_instr;
  logic        busy;
  logic        violation;

  always_comb begin
    busy      = (state == WAIT) || (state == RESP);
    violation = !mem_valid || (mem_addr != chk_addr) || (mem_wdata != lat_wdata) ||
                (mem_wstrb != lat_wstrb) || (mem_instr != chk_instr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_addr  <= '0;
      chk_instr <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && mem_valid) begin
        chk_addr  <= mem_addr;
        chk_instr <= mem_instr;
      end
      if (busy && violation) proto_err <= 1'b1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{mem_instr, mem_addr[31:AW+2], mem_addr[1:0]};
  assign proto_err   = 1'b0;
`endif

endmodule
